// File: rtl/mdu.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// 32-cycle shift-add multiply or restoring divide on magnitudes, then a sign fix-up cycle.
package cpu_types_pkg;
   typedef logic [31:0] word_t;
   typedef enum logic [1:0] {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU} mdop_t;
endpackage

module mdu
   import cpu_types_pkg::*;
(
   input  logic        CLK,
   input  logic        RST,
   input  logic        start,
   input  logic [1:0]  mdop,
   input  word_t       port_a,
   input  word_t       port_b,
   input  logic        flush,
   input  logic        hi_wen,
   input  logic        lo_wen,
   input  word_t       wdat,
   output word_t       hi,
   output word_t       lo,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t      state_q, state_d;
   logic [4:0]  cnt;
   mdop_t       op;
   word_t       a_reg, b_reg;
   logic        neg_a, neg_b;
   logic [63:0] acc;

   logic        start_ok, mt_ok, signed_op, start_div, op_div;
   word_t       a_mag, b_mag;
   logic [32:0] mul_sum, div_trial;
   logic [63:0] prod_fix;
   word_t       quo_fix, rem_fix, a_orig;

   assign busy      = (state_q != IDLE);
   assign start_ok  = (state_q == IDLE) && start && !flush;
   assign mt_ok     = (state_q == IDLE) && !start;
   assign signed_op = (mdop_t'(mdop) == MD_MULT) || (mdop_t'(mdop) == MD_DIV);
   assign start_div = (mdop_t'(mdop) == MD_DIV) || (mdop_t'(mdop) == MD_DIVU);
   assign op_div    = (op == MD_DIV) || (op == MD_DIVU);

   // NOTE: every output of a combinational block gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_ok) state_d = CALC;
         CALC:    if (flush) state_d = IDLE;
                  else if (cnt == 5'd31) state_d = FIX;
         FIX:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      a_mag = (signed_op && port_a[31]) ? -port_a : port_a;
      b_mag = (signed_op && port_b[31]) ? -port_b : port_b;
      // Multiply: acc = {partial product, remaining multiplier bits}.
      mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, a_reg} : 33'd0);
      // Divide: acc = {remainder, dividend/quotient}; trial subtract of the shifted remainder.
      div_trial = {acc[63:32], acc[31]} - {1'b0, b_reg};
      prod_fix  = (neg_a ^ neg_b) ? -acc : acc;
      quo_fix   = (neg_a ^ neg_b) ? -acc[31:0] : acc[31:0];
      rem_fix   = neg_a ? -acc[63:32] : acc[63:32];
      a_orig    = neg_a ? -a_reg : a_reg;
   end

   // NOTE: sequential state is updated only with non-blocking assignments so all registers
   // see the pre-edge values of each other.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         cnt     <= '0;
         op      <= MD_MULT;
         a_reg   <= '0;
         b_reg   <= '0;
         neg_a   <= 1'b0;
         neg_b   <= 1'b0;
         acc     <= '0;
         hi      <= '0;
         lo      <= '0;
         done    <= 1'b0;
      end else begin
         state_q <= state_d;
         done    <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start_ok) begin
                  op    <= mdop_t'(mdop);
                  cnt   <= '0;
                  a_reg <= a_mag;
                  b_reg <= b_mag;
                  neg_a <= signed_op && port_a[31];
                  neg_b <= signed_op && port_b[31];
                  acc   <= {32'd0, start_div ? a_mag : b_mag};
               end else if (mt_ok) begin
                  if (hi_wen) hi <= wdat;
                  if (lo_wen) lo <= wdat;
               end
            end
            CALC: begin
               if (!flush) begin
                  cnt <= cnt + 5'd1;
                  if (op_div) begin
                     if (!div_trial[32]) acc <= {div_trial[31:0], acc[30:0], 1'b1};
                     else                acc <= {acc[62:0], 1'b0};
                  end else begin
                     acc <= {mul_sum, acc[31:1]};
                  end
               end
            end
            FIX: begin
               if (!flush) begin
                  done <= 1'b1;
                  if (!op_div) begin
                     hi <= prod_fix[63:32];
                     lo <= prod_fix[31:0];
                  end else if (b_reg == '0) begin
                     hi <= a_orig;
                     lo <= 32'hFFFF_FFFF;
                  end else begin
                     hi <= rem_fix;
                     lo <= quo_fix;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
